// File: rtl/muldiv_pkg.sv
// Shared definitions for the multicycle multiply/divide unit and the control
// unit that issues mult/div/mfhi/mflo to it.
package muldiv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_RUN  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } md_state_e;

  localparam logic MD_MULT = 1'b0;
  localparam logic MD_DIV  = 1'b1;

  localparam logic [5:0] FUNCT_MULT = 6'b011000;
  localparam logic [5:0] FUNCT_DIV  = 6'b011010;
  localparam logic [5:0] FUNCT_MFHI = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO = 6'b010010;

  // True for the funct codes that launch an iterative operation.
  function automatic logic is_md_start(input logic [5:0] funct);
    return (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
  endfunction

  // Op select that goes with a launching funct code.
  function automatic logic md_op_of(input logic [5:0] funct);
    return (funct == FUNCT_DIV) ? MD_DIV : MD_MULT;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Multicycle signed mult/div owning the HI/LO registers. Magnitudes are run
// through a shared 2*WIDTH shift register, then the sign is fixed up.
//
//   state | meaning
//   IDLE  | waiting for start
//   PREP  | take magnitudes/signs of latched operands, catch div by zero
//   RUN   | WIDTH shift-add or restoring-divide iterations
//   FIX   | sign correction, HI/LO written on exit
//   DONE  | one-cycle result pulse; start here is accepted
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  md_state_e          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_top;
  logic               div_ok;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // INT_MIN negates to itself, which read unsigned is exactly 2^(WIDTH-1).
  assign abs_a = a_q[WIDTH-1] ? -a_q : a_q;
  assign abs_b = b_q[WIDTH-1] ? -b_q : b_q;

  // Multiplier sits in the low half and is consumed LSB-first.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // The shifted remainder needs one extra bit before the trial subtract.
  assign div_top  = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_ok   = (div_top >= {1'b0, mag_q});
  assign div_rem  = div_ok ? (div_top[WIDTH-1:0] - mag_q) : div_top[WIDTH-1:0];
  assign div_next = {div_rem, acc_q[WIDTH-2:0], div_ok};

  assign prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
  assign quo_fix  = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    dz_d     = dz_q;
    mag_d    = mag_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          dz_d    = 1'b0;
          state_d = ST_PREP;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_PREP: begin
        sign_a_d = a_q[WIDTH-1];
        sign_b_d = b_q[WIDTH-1];
        cnt_d    = '0;
        if (op_q == MD_DIV && b_q == '0) begin
          dz_d    = 1'b1;
          state_d = ST_DONE;
        end else if (op_q == MD_DIV) begin
          mag_d   = abs_b;
          acc_d   = {{WIDTH{1'b0}}, abs_a};
          state_d = ST_RUN;
        end else begin
          mag_d   = abs_a;
          acc_d   = {{WIDTH{1'b0}}, abs_b};
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        acc_d = (op_q == MD_DIV) ? div_next : mul_next;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        if (op_q == MD_DIV) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        state_d = ST_DONE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= MD_MULT;
      a_q      <= '0;
      b_q      <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dz_q     <= 1'b0;
      mag_q    <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      dz_q     <= dz_d;
      mag_q    <= mag_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy     = (state_q == ST_PREP) || (state_q == ST_RUN) || (state_q == ST_FIX);
  assign done     = (state_q == ST_DONE);
  assign div_zero = (state_q == ST_DONE) && dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
